key_press_conditioner: RTL and testbench

//   Conditions the raw active-low KEY push-buttons for the lab top levels.

---
 rtl/key_press_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_key_press_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_conditioner.sv
// key_press_conditioner: synchronises, debounces and edge-detects active-low
// push-buttons. Per key: PRESS / RELEASE one-cycle pulses and a HELD level.
// Optional auto-repeat is built when the macro KEY_REPEAT_EN is defined;
// otherwise REPEAT is tied low and no repeat counters exist.

module key_press_conditioner #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] PRESS,
    output logic [NUM_KEYS-1:0] RELEASE,
    output logic [NUM_KEYS-1:0] HELD,
    output logic [NUM_KEYS-1:0] REPEAT
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RCNT_W-1:0] RCNT_DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RCNT_PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
`endif

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic             s;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             held_q, held_d;

        assign s = sync2_q[k];

        // Debounce FSM next state: a change is accepted after a full stable window
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!s) begin
                        state_d = ST_PRESS_CHK;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (s) begin
                        state_d = ST_REL_CHK;
                        cnt_d   = '0;
                    end
                end
                ST_REL_CHK: begin
                    if (!s) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            held_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
        end

        // Debounce FSM state and registered outputs
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                held_q    <= held_d;
            end
        end

        assign PRESS[k]   = press_q;
        assign RELEASE[k] = release_q;
        assign HELD[k]    = held_q;

`ifdef KEY_REPEAT_EN
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              rphase_q, rphase_d;
        logic              repeat_q, repeat_d;

        // Auto-repeat timer: runs only while stably held, frozen during release check
        always_comb begin
            rcnt_d   = rcnt_q;
            rphase_d = rphase_q;
            repeat_d = 1'b0;
            if ((state_q == ST_PRESS_CHK) && (state_d == ST_HELD)) begin
                rcnt_d   = '0;
                rphase_d = 1'b0;
            end else if ((state_q == ST_HELD) && !s) begin
                if (rcnt_q == (rphase_q ? RCNT_PERIOD_LAST : RCNT_DELAY_LAST)) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                    rphase_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
        end

        // Auto-repeat registers
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                rcnt_q   <= '0;
                rphase_q <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                rcnt_q   <= rcnt_d;
                rphase_q <= rphase_d;
                repeat_q <= repeat_d;
            end
        end

        assign REPEAT[k] = repeat_q;
`else
        assign REPEAT[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with a per-cycle reference model.
// The model declares a change accepted once DEBOUNCE+1 consecutive
// synchronised samples agree; pulse edges are also pinned to literal values.

module tb_key_press_conditioner;

    localparam int unsigned NK = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key   = 2'b11;
    logic [NK-1:0] press, rel, held, rep;

    key_press_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .KEY     (key),
        .PRESS   (press),
        .RELEASE (rel),
        .HELD    (held),
        .REPEAT  (rep)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    // Reference model: sync pipeline, last D+1 samples, debounced level, repeat time
    logic [NK-1:0] m_p1 = '1, m_p2 = '1, m_sprev = '1;
    logic [D:0]    m_hist [NK];
    logic [NK-1:0] m_deb = '0, m_press = '0, m_rel = '0, m_rep = '0;
    int unsigned   m_t [NK];

    task automatic model_step();
        logic s;
        if (!rst_n) begin
            m_p1 = '1; m_p2 = '1; m_sprev = '1;
            m_deb = '0; m_press = '0; m_rel = '0; m_rep = '0;
            for (int k = 0; k < int'(NK); k++) begin
                m_hist[k] = '1;
                m_t[k]    = 0;
            end
        end else begin
            for (int k = 0; k < int'(NK); k++) begin
                s = m_p2[k];
                m_hist[k] = {m_hist[k][D-1:0], s};
                m_press[k] = 1'b0;
                m_rel[k]   = 1'b0;
                m_rep[k]   = 1'b0;
                if (!m_deb[k] && (m_hist[k] == '0)) begin
                    m_press[k] = 1'b1;
                    m_deb[k]   = 1'b1;
                    m_t[k]     = 0;
                end else if (m_deb[k] && (m_hist[k] == '1)) begin
                    m_rel[k] = 1'b1;
                    m_deb[k] = 1'b0;
                end else if (m_deb[k] && !s && !m_sprev[k]) begin
                    m_t[k]++;
`ifdef KEY_REPEAT_EN
                    if ((m_t[k] >= RD) && (((m_t[k] - RD) % RP) == 0)) m_rep[k] = 1'b1;
`endif
                end
                m_sprev[k] = s;
            end
            m_p2 = m_p1;
            m_p1 = key;
        end
    endtask

    initial begin
        for (int k = 0; k < int'(NK); k++) begin
            m_hist[k] = '1;
            m_t[k]    = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Pulse bookkeeping for literal timing checks
    int unsigned press_cnt [NK];
    int unsigned rel_cnt   [NK];
    int unsigned rep_cnt   [NK];
    int unsigned press_edge[NK];
    int unsigned rel_edge  [NK];
    int unsigned rep_first [NK];

    // Per-cycle compare against the model, sampled mid-cycle
    initial begin
        for (int k = 0; k < int'(NK); k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; rep_cnt[k] = 0;
            press_edge[k] = 0; rel_edge[k] = 0; rep_first[k] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("press", 32'(press), 32'(m_press));
            check("release", 32'(rel), 32'(m_rel));
            check("held", 32'(held), 32'(m_deb));
            check("repeat", 32'(rep), 32'(m_rep));
            for (int k = 0; k < int'(NK); k++) begin
                if (press[k]) begin press_cnt[k]++; press_edge[k] = edge_n; end
                if (rel[k])   begin rel_cnt[k]++;   rel_edge[k]   = edge_n; end
                if (rep[k]) begin
                    if (rep_cnt[k] == 0) rep_first[k] = edge_n;
                    rep_cnt[k]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned e0, el, pc0, pc1, rc0, rc1;

        // 1: reset with keys released
        rst_n = 1'b0; key = 2'b11;
        wait_cycles(3);
        check("reset_outs", 32'({press, rel, held, rep}), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // 2: clean press on key 0
        key = 2'b10; e0 = edge_n + 1;
        wait_cycles(20);
        check("s2_press0_cnt", press_cnt[0], 32'd1);
        check("s2_press0_edge", press_edge[0], e0 + 6);
        check("s2_press1_cnt", press_cnt[1], 32'd0);
        check("s2_held", 32'(held), 32'h1);

        // 3: clean release on key 0
        key = 2'b11; e0 = edge_n + 1;
        wait_cycles(12);
        check("s3_rel0_cnt", rel_cnt[0], 32'd1);
        check("s3_rel0_edge", rel_edge[0], e0 + 6);
        check("s3_held", 32'(held), 32'h0);

        // 4: bouncing press on key 1
        pc1 = press_cnt[1]; rc1 = rel_cnt[1];
        key = 2'b01; wait_cycles(1);
        key = 2'b11; wait_cycles(1);
        key = 2'b01; wait_cycles(1);
        key = 2'b11; wait_cycles(1);
        key = 2'b01; el = edge_n + 1;
        wait_cycles(15);
        check("s4_press1_cnt", press_cnt[1] - pc1, 32'd1);
        check("s4_press1_edge", press_edge[1], el + 6);
        check("s4_rel1_cnt", rel_cnt[1] - rc1, 32'd0);
        key = 2'b11;
        wait_cycles(12);

        // 5: simultaneous press, then reset while held
        pc0 = press_cnt[0]; pc1 = press_cnt[1];
        rc0 = rel_cnt[0];  rc1 = rel_cnt[1];
        key = 2'b00; e0 = edge_n + 1;
        wait_cycles(10);
        check("s5_press0_edge", press_edge[0], e0 + 6);
        check("s5_press1_edge", press_edge[1], e0 + 6);
        check("s5_held", 32'(held), 32'h3);
        rst_n = 1'b0;
        wait_cycles(1);
        check("s5_rst_outs", 32'({press, rel, held, rep}), 32'd0);
        wait_cycles(1);
        rst_n = 1'b1; e0 = edge_n + 1;
        wait_cycles(10);
        check("s5_repress0_cnt", press_cnt[0] - pc0, 32'd2);
        check("s5_repress1_edge", press_edge[1], e0 + 6);
        check("s5_no_release", (rel_cnt[0] - rc0) + (rel_cnt[1] - rc1), 32'd0);
        key = 2'b11;
        wait_cycles(12);

        // 6: long hold on key 0 for auto-repeat
        rc0 = rep_cnt[0];
        key = 2'b10; e0 = edge_n + 1;
        wait_cycles(30);
        key = 2'b11;
        wait_cycles(12);
`ifdef KEY_REPEAT_EN
        check("s6_rep_first", rep_first[0], e0 + 6 + RD);
        check("s6_rep_cnt", rep_cnt[0] - rc0, 32'd6);
`else
        check("s6_rep_cnt", rep_cnt[0] - rc0, 32'd0);
`endif
        check("s6_rep1_cnt", rep_cnt[1], 32'd0);
        check("s6_held_end", 32'(held), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
